// File: rtl/leaf_interface_mc_if.sv
// rtl/leaf_interface_mc_if.sv - BFT leaf link, user stream and status signals of the multi-channel leaf interface
interface leaf_interface_mc_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 4,
  parameter int NUM_OUT_PORTS = 4
);
  logic [PACKET_BITS-1:0]                  i_bft_data;
  logic [PACKET_BITS-1:0]                  o_bft_data;
  logic                                    i_bft_ready;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    i_user_data;
  logic [NUM_IN_PORTS-1:0]                 i_user_valid;
  logic [NUM_IN_PORTS-1:0]                 o_user_ready;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   o_user_data;
  logic [NUM_OUT_PORTS-1:0]                o_user_valid;
  logic [NUM_OUT_PORTS-1:0]                i_user_ready;
  logic [1:0]                              o_status;
  logic                                    i_status_clr;

  modport slave (
    input  i_bft_data, i_bft_ready, i_user_data, i_user_valid, i_user_ready, i_status_clr,
    output o_bft_data, o_user_ready, o_user_data, o_user_valid, o_status
  );

  modport master (
    output i_bft_data, i_bft_ready, i_user_data, i_user_valid, i_user_ready, i_status_clr,
    input  o_bft_data, o_user_ready, o_user_data, o_user_valid, o_status
  );
endinterface

// File: rtl/leaf_interface_mc.sv
// rtl/leaf_interface_mc.sv - round-robin BFT packetiser and per-port FIFO depacketiser
// Optional packet counters are enabled with LEAF_IF_PERF_CNT_EN.
module leaf_interface_mc #(
  parameter int PACKET_BITS     = 49,
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_LEAF_BITS   = 5,
  parameter int NUM_PORT_BITS   = 4,
  parameter int NUM_ADDR_BITS   = 7,
  parameter int NUM_IN_PORTS    = 4,
  parameter int NUM_OUT_PORTS   = 4,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  leaf_interface_mc_if.slave  bus
`ifdef LEAF_IF_PERF_CNT_EN
  ,
  output logic [31:0]         o_tx_count,
  output logic [31:0]         o_rx_count
`endif
);
  localparam int EB       = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int DEPTH    = 1 << FIFO_DEPTH_BITS;
  localparam int ADDR_LSB = PAYLOAD_BITS;
  localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int PTR_W    = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;
  localparam int MSB      = PACKET_BITS - 1;

  // Incoming packets are registered once before decode, giving a two-edge RX latency.
  logic                     rx_vld;
  logic [NUM_PORT_BITS-1:0] rx_port;
  logic [NUM_ADDR_BITS-1:0] rx_addr;
  logic [PAYLOAD_BITS-1:0]  rx_payload;

  logic [NUM_IN_PORTS-1:0]          tbl_vld;
  logic [NUM_IN_PORTS-1:0][EB-1:0]  tbl_dest;
  logic                             cfg_we;
  logic                             bad_set;
  logic [NUM_OUT_PORTS-1:0]         push;
  logic [NUM_OUT_PORTS-1:0]         wr;
  logic [NUM_OUT_PORTS-1:0]         drop;
  logic [1:0]                       status;

  logic [PACKET_BITS-1:0]   tx_q;
  logic [PACKET_BITS-1:0]   tx_word;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         rr_next;
  logic [NUM_IN_PORTS-1:0]  grant;
  logic                     tx_free;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_vld     <= 1'b0;
      rx_port    <= '0;
      rx_addr    <= '0;
      rx_payload <= '0;
    end else begin
      rx_vld     <= bus.i_bft_data[MSB];
      rx_port    <= bus.i_bft_data[PORT_LSB +: NUM_PORT_BITS];
      rx_addr    <= bus.i_bft_data[ADDR_LSB +: NUM_ADDR_BITS];
      rx_payload <= bus.i_bft_data[PAYLOAD_BITS-1:0];
    end
  end

  always_comb begin
    cfg_we  = 1'b0;
    bad_set = 1'b0;
    push    = '0;
    if (rx_vld) begin
      if (rx_port == '0) begin
        if (rx_addr < NUM_ADDR_BITS'(NUM_IN_PORTS)) cfg_we = 1'b1;
        else                                        bad_set = 1'b1;
      end else if (rx_port > NUM_PORT_BITS'(NUM_OUT_PORTS)) begin
        bad_set = 1'b1;
      end else begin
        for (int p = 0; p < NUM_OUT_PORTS; p++)
          if (rx_port == NUM_PORT_BITS'(p + 1)) push[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_vld  <= '0;
      tbl_dest <= '0;
    end else begin
      for (int e = 0; e < NUM_IN_PORTS; e++) begin
        if (cfg_we && rx_addr == NUM_ADDR_BITS'(e)) begin
          tbl_vld[e]  <= 1'b1;
          tbl_dest[e] <= rx_payload[EB-1:0];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_fifo
    logic [PAYLOAD_BITS-1:0]  mem [DEPTH];
    logic [FIFO_DEPTH_BITS:0] wptr;
    logic [FIFO_DEPTH_BITS:0] rptr;
    logic                     empty;
    logic                     full;
    logic                     pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[FIFO_DEPTH_BITS] != rptr[FIFO_DEPTH_BITS]) &&
                     (wptr[FIFO_DEPTH_BITS-1:0] == rptr[FIFO_DEPTH_BITS-1:0]);
    assign pop     = !empty && bus.i_user_ready[g];
    // A simultaneous pop frees the slot the push lands in, so a full FIFO still accepts.
    assign wr[g]   = push[g] && (!full || pop);
    assign drop[g] = push[g] && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr[g]) wptr <= wptr + 1'b1;
        if (pop)   rptr <= rptr + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (wr[g]) mem[wptr[FIFO_DEPTH_BITS-1:0]] <= rx_payload;
    end

    assign bus.o_user_data[g*PAYLOAD_BITS +: PAYLOAD_BITS] = mem[rptr[FIFO_DEPTH_BITS-1:0]];
    assign bus.o_user_valid[g] = !empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                status <= 2'b00;
    else if (bus.i_status_clr) status <= {bad_set, |drop};
    else                       status <= status | {bad_set, |drop};
  end

  assign bus.o_status = status;

  assign tx_free = !tx_q[MSB] || bus.i_bft_ready;

  // Two passes: channels at or above the pointer first, then wrap to the low channels.
  always_comb begin : p_arb
    logic found;
    int   k;
    found   = 1'b0;
    k       = 0;
    grant   = '0;
    tx_word = '0;
    rr_next = rr_ptr;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (!found && tx_free && bus.i_user_valid[i] && tbl_vld[i] && PTR_W'(i) >= rr_ptr) begin
        found = 1'b1;
        k     = i;
      end
    end
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (!found && tx_free && bus.i_user_valid[i] && tbl_vld[i]) begin
        found = 1'b1;
        k     = i;
      end
    end
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (found && k == i) begin
        grant[i] = 1'b1;
        tx_word  = {1'b1, tbl_dest[i], NUM_ADDR_BITS'(i + 1),
                    bus.i_user_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
        rr_next  = PTR_W'((i + 1) % NUM_IN_PORTS);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q   <= '0;
      rr_ptr <= '0;
    end else if (|grant) begin
      tx_q   <= tx_word;
      rr_ptr <= rr_next;
    end else if (bus.i_bft_ready) begin
      tx_q[MSB] <= 1'b0;
    end
  end

  assign bus.o_bft_data   = tx_q;
  assign bus.o_user_ready = grant;

`ifdef LEAF_IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_tx_count <= '0;
      o_rx_count <= '0;
    end else begin
      if (tx_q[MSB] && bus.i_bft_ready) o_tx_count <= o_tx_count + 32'd1;
      if (|wr)                          o_rx_count <= o_rx_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_leaf_interface_mc.sv
// tb/tb_leaf_interface_mc.sv - directed self-checking bench for leaf_interface_mc
module tb_leaf_interface_mc;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  leaf_interface_mc_if #(.PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_IN_PORTS(4), .NUM_OUT_PORTS(4)) bus ();

`ifdef LEAF_IF_PERF_CNT_EN
  logic [31:0] tx_count;
  logic [31:0] rx_count;
`endif

  leaf_interface_mc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef LEAF_IF_PERF_CNT_EN
    ,
    .o_tx_count (tx_count),
    .o_rx_count (rx_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [48:0] mkpkt(input int leaf, input int port, input int addr, input logic [31:0] pl);
    mkpkt = {1'b1, 5'(leaf), 4'(port), 7'(addr), pl};
  endfunction

  function automatic logic [48:0] word(input int k);
    word = {1'b1, 5'(k + 1), 4'(k + 4), 7'(k + 1), 32'hA000_0000 + 32'(k)};
  endfunction

  task automatic rx_send(input logic [48:0] pkt);
    bus.i_bft_data = pkt;
    tick();
    bus.i_bft_data = '0;
  endtask

  task automatic cfg(input int addr, input int leaf, input int port);
    rx_send(mkpkt(0, 0, addr, {23'b0, 5'(leaf), 4'(port)}));
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.i_bft_data   = '0;
    bus.i_bft_ready  = 1'b0;
    bus.i_user_data  = '0;
    bus.i_user_valid = 4'b0001;
    bus.i_user_ready = '0;
    bus.i_status_clr = 1'b0;

    // 1. reset state
    #12;
    chk("rst_bft", 64'(bus.o_bft_data), 64'h0);
    chk("rst_uvalid", 64'(bus.o_user_valid), 64'h0);
    chk("rst_status", 64'(bus.o_status), 64'h0);
    chk("rst_uready", 64'(bus.o_user_ready), 64'h0);
    tick();
    reset = 1'b1;
    bus.i_bft_ready = 1'b1;
    tick();
    chk("empty_tbl_uready", 64'(bus.o_user_ready), 64'h0);
    chk("empty_tbl_bft", 64'(bus.o_bft_data), 64'h0);
    bus.i_user_valid = '0;

    // 2. config ch1 -> leaf 3 / port 2, then send one word
    cfg(1, 3, 2);
    bus.i_user_valid = 4'b0010;
    bus.i_user_data[63:32] = 32'hDEADBEEF;
    #1;
    chk("cfg_grant", 64'(bus.o_user_ready), 64'h2);
    tick();
    bus.i_user_valid = '0;
    chk("cfg_tx_word", 64'(bus.o_bft_data), 64'({1'b1, 5'd3, 4'd2, 7'd2, 32'hDEADBEEF}));
    tick();
    chk("tx_valid_clear", 64'(bus.o_bft_data[48]), 64'h0);

    // 3. round robin under backpressure, from a fresh reset
    reset = 1'b0;
    #2;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) cfg(k, k + 1, k + 4);
    for (int k = 0; k < 4; k++) bus.i_user_data[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    bus.i_user_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      bus.i_bft_ready = 1'b1;
      #1;
      chk("rr_grant", 64'(bus.o_user_ready), 64'(4'b0001 << (n % 4)));
      tick();
      chk("rr_word", 64'(bus.o_bft_data), 64'(word(n % 4)));
      bus.i_bft_ready = 1'b0;
      #1;
      chk("bp_no_grant", 64'(bus.o_user_ready), 64'h0);
      tick();
      chk("bp_hold", 64'(bus.o_bft_data), 64'(word(n % 4)));
    end
    bus.i_user_valid = '0;
    bus.i_bft_ready  = 1'b1;
    tick();

    // 4. overflow of port 1 FIFO, latency and pop order
    bus.i_bft_data = mkpkt(0, 1, 0, 32'd1);
    tick();
    chk("rx_lat_edge1", 64'(bus.o_user_valid[0]), 64'h0);
    for (int w = 2; w <= 9; w++) begin
      bus.i_bft_data = mkpkt(0, 1, 0, 32'(w));
      tick();
      if (w == 2) chk("rx_lat_edge2", 64'(bus.o_user_valid[0]), 64'h1);
    end
    bus.i_bft_data = '0;
    tick();
    chk("ovf_uvalid", 64'(bus.o_user_valid), 64'h1);
    chk("ovf_status", 64'(bus.o_status), 64'h1);
    bus.i_user_ready = 4'b0001;
    for (int w = 1; w <= 8; w++) begin
      chk("ovf_pop", 64'(bus.o_user_data[31:0]), 64'(w));
      tick();
    end
    bus.i_user_ready = '0;
    chk("ovf_drained", 64'(bus.o_user_valid), 64'h0);
    bus.i_status_clr = 1'b1;
    tick();
    bus.i_status_clr = 1'b0;
    chk("ovf_clr", 64'(bus.o_status), 64'h0);

    // 5. full FIFO on port 2, push and pop on the same edge
    for (int w = 1; w <= 8; w++) begin
      bus.i_bft_data = mkpkt(0, 2, 0, 32'h100 + 32'(w));
      tick();
    end
    bus.i_bft_data = mkpkt(0, 2, 0, 32'h109);
    tick();
    bus.i_bft_data = '0;
    chk("full_uvalid", 64'(bus.o_user_valid), 64'h2);
    bus.i_user_ready = 4'b0010;
    tick();
    bus.i_user_ready = '0;
    chk("full_pushpop_status", 64'(bus.o_status), 64'h0);
    bus.i_user_ready = 4'b0010;
    for (int w = 2; w <= 9; w++) begin
      chk("full_pop", 64'(bus.o_user_data[63:32]), 64'(32'h100 + 32'(w)));
      tick();
    end
    bus.i_user_ready = '0;
    chk("full_drained", 64'(bus.o_user_valid), 64'h0);

    // 6. bad port, bad config index, clear and set-wins
    rx_send(mkpkt(0, 15, 0, 32'h55));
    tick();
    chk("bad_port_status", 64'(bus.o_status), 64'h2);
    chk("bad_port_no_push", 64'(bus.o_user_valid), 64'h0);
    bus.i_status_clr = 1'b1;
    tick();
    bus.i_status_clr = 1'b0;
    chk("bad_port_clr", 64'(bus.o_status), 64'h0);
    rx_send(mkpkt(0, 0, 9, 32'h32));
    bus.i_status_clr = 1'b1;
    tick();
    bus.i_status_clr = 1'b0;
    chk("bad_cfg_set_wins", 64'(bus.o_status), 64'h2);
    bus.i_status_clr = 1'b1;
    tick();
    bus.i_status_clr = 1'b0;
    chk("bad_cfg_clr", 64'(bus.o_status), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
